// File: rtl/bf_mem_responder.sv
// Memory-side responder for the bf core's shared 8-bit bus: latches addresses,
// serves snapshot reads, commits writes, and accepts host preloads while the core bus is idle.
module bf_mem_responder #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          write,
  input  logic          addr,
  input  logic [7:0]    bus_in,
  output logic [7:0]    bus_out,
  output logic          bus_oe,
  input  logic          load_valid,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  output logic          proto_err,
  output logic          state_dbg
);

  // Handshake: a load transfers on an edge where load_valid && load_ready are both
  // high; load_ready never depends on load_valid, and the core bus always has priority.

  typedef enum logic {
    IDLE      = 1'b0,
    ADDR_HELD = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] addr_q;
  logic [7:0]    rdata_q;
  logic [7:0]    mem [DEPTH];

  logic          latch_addr;
  logic          err_set;
  logic          core_we;
  logic          load_we;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [AW-1:0] bus_idx;

  assign bus_idx   = bus_in[AW-1:0];
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    latch_addr = 1'b0;
    err_set    = 1'b0;
    core_we    = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (write && addr) begin
            latch_addr = 1'b1;
            state_next = ADDR_HELD;
          end else if (write != addr) begin
            // Data without an address, or an address qualifier without a strobe.
            err_set = 1'b1;
          end
        end
        ADDR_HELD: begin
          if (write && addr) begin
            latch_addr = 1'b1;
          end else if (write) begin
            core_we    = 1'b1;
            state_next = IDLE;
          end else begin
            err_set    = addr;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    bus_oe     = 1'b0;
    bus_out    = 8'h00;
    load_ready = 1'b0;
    if (!reset) begin
      // Held independent of en so a stalled read phase keeps presenting its data.
      if (state == ADDR_HELD && !write) begin
        bus_oe  = 1'b1;
        bus_out = rdata_q;
      end
      load_ready = (state == IDLE) && !write && !addr;
    end
  end

  assign load_we   = load_valid && load_ready;
  assign mem_we    = !reset && (core_we || load_we);
  assign mem_waddr = core_we ? addr_q : load_addr;
  assign mem_wdata = core_we ? bus_in : load_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      rdata_q   <= 8'h00;
      proto_err <= 1'b0;
    end else begin
      state <= state_next;
      if (latch_addr) begin
        addr_q  <= bus_idx;
        rdata_q <= mem[bus_idx];
      end
      if (err_set) begin
        proto_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_bf_mem_responder.sv
// Directed bench for bf_mem_responder: stimulus pushes expected read bytes into
// queues and negedge monitors pop them whenever bus_oe is presented.
module tb_bf_mem_responder;

  logic       clk = 1'b0;
  logic       reset, en, write, addr, load_valid, load_ready, proto_err, bus_oe, state_dbg;
  logic [7:0] bus_in, bus_out, load_addr, load_data;

  logic       s_reset, s_en, s_write, s_addr, s_load_valid, s_load_ready, s_proto_err;
  logic       s_bus_oe, s_state_dbg;
  logic [7:0] s_bus_in, s_bus_out, s_load_data;
  logic [3:0] s_load_addr;

  logic [7:0] exp_q[$];
  logic [7:0] exp16_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  bf_mem_responder #(.DEPTH(256), .AW(8)) dut (
    .clk(clk), .reset(reset), .en(en), .write(write), .addr(addr), .bus_in(bus_in),
    .bus_out(bus_out), .bus_oe(bus_oe), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_ready(load_ready), .proto_err(proto_err),
    .state_dbg(state_dbg)
  );

  bf_mem_responder #(.DEPTH(16), .AW(4)) dut16 (
    .clk(clk), .reset(s_reset), .en(s_en), .write(s_write), .addr(s_addr),
    .bus_in(s_bus_in), .bus_out(s_bus_out), .bus_oe(s_bus_oe), .load_valid(s_load_valid),
    .load_addr(s_load_addr), .load_data(s_load_data), .load_ready(s_load_ready),
    .proto_err(s_proto_err), .state_dbg(s_state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_oe) begin
      if (exp_q.size() == 0) begin
        check("unexpected_oe", {24'h0, bus_out}, 32'hffff_ffff);
      end else begin
        check("read_data", {24'h0, bus_out}, {24'h0, exp_q.pop_front()});
      end
    end
    if (s_bus_oe) begin
      if (exp16_q.size() == 0) begin
        check("unexpected_oe16", {24'h0, s_bus_out}, 32'hffff_ffff);
      end else begin
        check("read_data16", {24'h0, s_bus_out}, {24'h0, exp16_q.pop_front()});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic w, input logic a, input logic [7:0] d);
    write  = w;
    addr   = a;
    bus_in = d;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    bus(1'b0, 1'b0, 8'h00);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    #1;
    check("load_ready_idle", load_ready, 1);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic core_read(input logic [7:0] a, input logic [7:0] exp);
    bus(1'b1, 1'b1, a);
    exp_q.push_back(exp);
    tick();
    bus(1'b0, 1'b0, 8'h00);
    tick();
  endtask

  task automatic core_write(input logic [7:0] a, input logic [7:0] d);
    bus(1'b1, 1'b1, a);
    tick();
    bus(1'b1, 1'b0, d);
    tick();
    bus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; load_valid = 1'b0; load_addr = 8'h00; load_data = 8'h00;
    bus(1'b0, 1'b0, 8'h00);
    s_reset = 1'b1; s_en = 1'b1; s_write = 1'b0; s_addr = 1'b0; s_bus_in = 8'h00;
    s_load_valid = 1'b0; s_load_addr = 4'h0; s_load_data = 8'h00;
    tick();
    tick();
    check("load_ready_in_reset", load_ready, 0);
    reset = 1'b0;
    s_reset = 1'b0;
    #1;
    check("reset_state", state_dbg, 0);
    check("reset_oe", bus_oe, 0);
    check("reset_bus_out", bus_out, 0);
    check("reset_proto_err", proto_err, 0);
    check("reset_load_ready", load_ready, 1);

    // Program preload and first read
    load(8'h00, 8'h2B);
    load(8'h01, 8'h2B);
    load(8'h02, 8'h5D);
    core_read(8'h00, 8'h2B);
    check("state_after_read", state_dbg, 0);
    check("oe_after_read", bus_oe, 0);
    core_read(8'h02, 8'h5D);

    // Core write then read back
    core_write(8'h10, 8'h7F);
    core_read(8'h10, 8'h7F);

    // Re-latch in ADDR_HELD: the second address wins
    bus(1'b1, 1'b1, 8'h10);
    tick();
    bus(1'b1, 1'b1, 8'h01);
    exp_q.push_back(8'h2B);
    tick();
    bus(1'b0, 1'b0, 8'h00);
    tick();

    // Stalled read phase holds its data
    load(8'h05, 8'h3C);
    bus(1'b1, 1'b1, 8'h05);
    tick();
    en = 1'b0;
    bus(1'b0, 1'b0, 8'h00);
    repeat (4) exp_q.push_back(8'h3C);
    for (int i = 0; i < 3; i++) begin
      check("stall_state", state_dbg, 1);
      check("stall_load_ready", load_ready, 0);
      tick();
    end
    en = 1'b1;
    tick();
    check("state_after_stall", state_dbg, 0);

    // Orphan data phase
    bus(1'b1, 1'b0, 8'h55);
    tick();
    bus(1'b0, 1'b0, 8'h00);
    check("orphan_err", proto_err, 1);
    check("orphan_state", state_dbg, 0);
    core_read(8'h10, 8'h7F);
    check("err_sticky", proto_err, 1);
    pulse_reset();
    check("err_cleared", proto_err, 0);
    check("oe_after_reset", bus_oe, 0);

    // Address qualifier without strobe
    bus(1'b0, 1'b1, 8'h00);
    tick();
    bus(1'b0, 1'b0, 8'h00);
    check("addr_only_err", proto_err, 1);
    pulse_reset();

    // Read phase with addr=1 still returns data but flags an error
    bus(1'b1, 1'b1, 8'h01);
    exp_q.push_back(8'h2B);
    tick();
    bus(1'b0, 1'b1, 8'h00);
    tick();
    bus(1'b0, 1'b0, 8'h00);
    check("read_addr_err", proto_err, 1);
    check("read_addr_state", state_dbg, 0);
    pulse_reset();

    // Load collides with core activity
    load(8'h20, 8'h11);
    load_valid = 1'b1; load_addr = 8'h20; load_data = 8'h99;
    bus(1'b1, 1'b1, 8'h20);
    exp_q.push_back(8'h11);
    #1;
    check("load_blocked_addr", load_ready, 0);
    tick();
    bus(1'b0, 1'b0, 8'h00);
    #1;
    check("load_blocked_read", load_ready, 0);
    tick();
    check("load_ready_again", load_ready, 1);
    tick();
    load_valid = 1'b0;
    core_read(8'h20, 8'h99);

    // DEPTH=16: address wrap
    s_write = 1'b1; s_addr = 1'b1; s_bus_in = 8'h13;
    tick();
    s_addr = 1'b0; s_bus_in = 8'hAA;
    tick();
    s_write = 1'b1; s_addr = 1'b1; s_bus_in = 8'h03;
    exp16_q.push_back(8'hAA);
    tick();
    s_write = 1'b0; s_addr = 1'b0; s_bus_in = 8'h00;
    tick();
    s_load_valid = 1'b1; s_load_addr = 4'h4; s_load_data = 8'h44;
    tick();
    s_load_valid = 1'b0;

    // DEPTH=16: reset between address and data phase drops the write
    s_write = 1'b1; s_addr = 1'b1; s_bus_in = 8'h04;
    tick();
    s_reset = 1'b1; s_write = 1'b0; s_addr = 1'b0;
    tick();
    s_reset = 1'b0;
    check("s_reset_state", s_state_dbg, 0);
    s_write = 1'b1; s_bus_in = 8'hEE;
    tick();
    s_write = 1'b0; s_bus_in = 8'h00;
    check("s_orphan_err", s_proto_err, 1);
    s_write = 1'b1; s_addr = 1'b1; s_bus_in = 8'h14;
    exp16_q.push_back(8'h44);
    tick();
    s_write = 1'b0; s_addr = 1'b0; s_bus_in = 8'h00;
    tick();
    tick();

    check("exp_q_drained", exp_q.size(), 0);
    check("exp16_q_drained", exp16_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
